latch_wr_ctrl: RTL and testbench
================================

LATCH_WR_CTRL -- requirements
Module: latch_wr_ctrl

Interface
REQ-001 SHALL have parameter NUM_LATCH, default 4, number of 4-bit latches driven (2..16).
REQ-002 SHALL have parameter SETUP_CYC, default 1, cycles data is stable before gate opens (>=1).
REQ-003 SHALL have parameter PULSE_CYC, default 2, cycles gate is held open (>=1).
REQ-004 SHALL have parameter HOLD_CYC, default 1, cycles data is held after gate closes (>=1).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req  input  1  write request, sampled only in IDLE.
REQ-008 SHALL have port addr  input  AW=$clog2(NUM_LATCH)  target latch index.
REQ-009 SHALL have port wdata  input  4  data to write.
REQ-010 SHALL have port preset_all  input  1  request to preset every latch to 4'b1111.
REQ-011 SHALL have port d  output  4  shared latch data bus, registered.
REQ-012 SHALL have port g  output  NUM_LATCH  per-latch gate, active-low (0 = transparent), registered.
REQ-013 SHALL have port pre  output  1  broadcast preset to all latches, active-high, registered.
REQ-014 SHALL have port busy  output  1  high while a write or preset sequence runs.
REQ-015 SHALL have port done  output  1  one-cycle pulse in the final cycle of a sequence.
REQ-016 SHALL have port err  output  1  one-cycle pulse with done when addr >= NUM_LATCH.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, PULSE, HOLD, PRESET with one shared cycle counter.
REQ-018 In IDLE, with busy=0: preset_all=1 -> PRESET; else req=1 -> SETUP, capturing addr and wdata.
REQ-019 preset_all and req both high in IDLE: preset wins; the req is dropped, not queued.
REQ-020 req or preset_all while busy=1 SHALL be ignored, with no effect on the running sequence.
REQ-021 SETUP: d = captured wdata, all g = 1, pre = 0, for exactly SETUP_CYC cycles, then PULSE.
REQ-022 PULSE: g[addr] = 0, all other g = 1, d held, for exactly PULSE_CYC cycles, then HOLD.
REQ-023 HOLD: all g = 1, d held, for exactly HOLD_CYC cycles; done = 1 in the last HOLD cycle, then IDLE.
REQ-024 PRESET: pre = 1, all g = 1, d unchanged, for PULSE_CYC cycles; done = 1 in the last cycle, then IDLE.
REQ-025 busy SHALL be 1 in every non-IDLE cycle: exactly SETUP_CYC+PULSE_CYC+HOLD_CYC cycles for a write, PULSE_CYC cycles for a preset.
REQ-026 The first output change SHALL appear the cycle after the accepting edge (registered outputs).
REQ-027 addr >= NUM_LATCH: the full timing SHALL run with no g bit low, and err = 1 together with done.
REQ-028 A new req held high through done SHALL be accepted on the first IDLE edge, i.e. back-to-back with one IDLE cycle.
REQ-029 At most one g bit SHALL be low in any cycle, and no g bit SHALL be low while pre = 1.
REQ-030 d SHALL change only on the transition into SETUP; d SHALL never change while any g bit is low.

Reset
REQ-031 rst_n = 0 SHALL immediately force state IDLE, d = 4'b0000, g = all ones, pre = 0, busy = 0, done = 0, err = 0, counter = 0.
REQ-032 Reset during PULSE or PRESET SHALL close the gate or drop pre immediately, with no done pulse.
REQ-033 After rst_n deasserts, the first rising edge SHALL behave as IDLE sampling.

Verification (defaults, NUM_LATCH=4; cycle n = nth cycle after the accepting edge)
REQ-034 req=1, addr=2, wdata=4'b0101 -> d=0101 from cycle 1; g=4'b1011 in cycles 2-3; busy in cycles 1-4; done in cycle 4.
REQ-035 preset_all=1 and req=1 together -> pre=1 and busy=1 in cycles 1-2, g all ones, done in cycle 2, req dropped.
REQ-036 req=1, addr=3; a second req with addr=0 during cycle 2 -> only g[3] pulses; the second request is ignored.
REQ-037 rst_n=0 asynchronously in cycle 2 of a write to addr 1 -> g=4'b1111, busy=0 before the next edge; no done.
REQ-038 req held high for 12 cycles, addr=1 -> writes accepted at edges 0 and 5; done in cycles 4 and 9.
REQ-039 NUM_LATCH=3, addr=3 -> g never low; done=err=1 in cycle 4.

Source files
------------

// File: rtl/latch_wr_ctrl.sv
// latch_wr_ctrl: sequences setup/gate/hold timing for a bank of 4-bit
// transparent latches sharing one data bus, plus a broadcast preset.
module latch_wr_ctrl #(
    parameter int NUM_LATCH = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req,
    input  logic [$clog2(NUM_LATCH)-1:0] addr,
    input  logic [3:0]                   wdata,
    input  logic                         preset_all,
    output logic [3:0]                   d,
    output logic [NUM_LATCH-1:0]         g,
    output logic                         pre,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    localparam int AW   = $clog2(NUM_LATCH);
    localparam int MAXC = (SETUP_CYC > PULSE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                                  : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, PRESET} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [AW-1:0]        addr_q, addr_n;
    logic [3:0]           d_n;
    logic [NUM_LATCH-1:0] g_n;
    logic                 pre_n, busy_n, done_n, err_n;

    // Counter counts cycles spent in the current state; cnt_n is its value in state_n.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        addr_n  = addr_q;
        d_n     = d;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (preset_all) begin
                    state_n = PRESET;
                end else if (req) begin
                    state_n = SETUP;
                    addr_n  = addr;
                    d_n     = wdata;
                end
            end
            SETUP:  if (cnt == CW'(SETUP_CYC - 1)) begin state_n = PULSE; cnt_n = '0; end
            PULSE:  if (cnt == CW'(PULSE_CYC - 1)) begin state_n = HOLD;  cnt_n = '0; end
            HOLD:   if (cnt == CW'(HOLD_CYC - 1))  begin state_n = IDLE;  cnt_n = '0; end
            PRESET: if (cnt == CW'(PULSE_CYC - 1)) begin state_n = IDLE;  cnt_n = '0; end
            default: begin state_n = IDLE; cnt_n = '0; end
        endcase
        // Outputs are decoded from the next state so they register alongside it.
        g_n = '1;
        for (int i = 0; i < NUM_LATCH; i++) g_n[i] = !(state_n == PULSE && addr_n == AW'(i));
        pre_n  = state_n == PRESET;
        busy_n = state_n != IDLE;
        done_n = (state_n == HOLD && cnt_n == CW'(HOLD_CYC - 1)) ||
                 (state_n == PRESET && cnt_n == CW'(PULSE_CYC - 1));
        err_n  = done_n && state_n == HOLD && int'(addr_n) >= NUM_LATCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            d      <= 4'b0000;
            g      <= '1;
            pre    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            addr_q <= addr_n;
            d      <= d_n;
            g      <= g_n;
            pre    <= pre_n;
            busy   <= busy_n;
            done   <= done_n;
            err    <= err_n;
        end
    end
endmodule

// File: tb/tb_latch_wr_ctrl.sv
// tb_latch_wr_ctrl: directed and random stimulus on two configurations,
// checked cycle by cycle against a schedule-based reference model.
module tb_latch_wr_ctrl;
    typedef struct packed {
        logic [3:0] d;
        logic [3:0] g;
        logic       pre, busy, done, err;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0, req = 1'b0, preset_all = 1'b0;
    logic [1:0] addr = '0;
    logic [3:0] wdata = '0;
    logic [3:0] d0, d1, g0;
    logic [2:0] g1;
    logic       pre0, busy0, done0, err0, pre1, busy1, done1, err1;
    int         checks = 0, errors = 0;

    exp_t cur [2];
    exp_t sched [2][16];
    int   len [2], pos [2];

    latch_wr_ctrl u0 (.clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .wdata(wdata),
                      .preset_all(preset_all), .d(d0), .g(g0), .pre(pre0), .busy(busy0),
                      .done(done0), .err(err0));
    latch_wr_ctrl #(.NUM_LATCH(3), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u1 (
                      .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .wdata(wdata),
                      .preset_all(preset_all), .d(d1), .g(g1), .pre(pre1), .busy(busy1),
                      .done(done1), .err(err1));

    always #5 clk = ~clk;

    function automatic int nl(int k);   return k ? 3 : 4; endfunction
    function automatic int su(int k);   return k ? 2 : 1; endfunction
    function automatic int pw(int k);   return k ? 3 : 2; endfunction
    function automatic int ho(int k);   return k ? 2 : 1; endfunction
    function automatic logic [3:0] ones(int k); return k ? 4'b0111 : 4'b1111; endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            cur[k] = '{d: 4'h0, g: ones(k), pre: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
            len[k] = 0;
            pos[k] = 0;
        end
    endtask

    // At each edge an idle model accepts a request by laying out the whole
    // timeline of the sequence, then plays it back one cycle per edge.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (!cur[k].busy && preset_all) begin
                len[k] = pw(k);
                pos[k] = 0;
                for (int t = 0; t < len[k]; t++)
                    sched[k][t] = '{d: cur[k].d, g: ones(k), pre: 1'b1, busy: 1'b1,
                                    done: t == len[k] - 1, err: 1'b0};
            end else if (!cur[k].busy && req) begin
                len[k] = su(k) + pw(k) + ho(k);
                pos[k] = 0;
                for (int t = 0; t < len[k]; t++)
                    sched[k][t] = '{d: wdata,
                                    g: (t >= su(k) && t < su(k) + pw(k) && int'(addr) < nl(k))
                                       ? ones(k) & ~(4'b0001 << addr) : ones(k),
                                    pre: 1'b0, busy: 1'b1, done: t == len[k] - 1,
                                    err: t == len[k] - 1 && int'(addr) >= nl(k)};
            end
            if (pos[k] < len[k]) begin
                cur[k] = sched[k][pos[k]];
                pos[k]++;
            end else begin
                cur[k] = '{d: cur[k].d, g: ones(k), pre: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        chk("d0", d0, cur[0].d);
        chk("g0", g0, cur[0].g);
        chk("pre0", {3'b0, pre0}, {3'b0, cur[0].pre});
        chk("busy0", {3'b0, busy0}, {3'b0, cur[0].busy});
        chk("done0", {3'b0, done0}, {3'b0, cur[0].done});
        chk("err0", {3'b0, err0}, {3'b0, cur[0].err});
        chk("d1", d1, cur[1].d);
        chk("g1", {1'b0, g1}, cur[1].g);
        chk("pre1", {3'b0, pre1}, {3'b0, cur[1].pre});
        chk("busy1", {3'b0, busy1}, {3'b0, cur[1].busy});
        chk("done1", {3'b0, done1}, {3'b0, cur[1].done});
        chk("err1", {3'b0, err1}, {3'b0, cur[1].err});
        chk("gate_excl0", {3'b0, $countones(~g0) <= 1 && !(pre0 && g0 != 4'hf)}, 4'h1);
        chk("gate_excl1", {3'b0, $countones(~g1) <= 1 && !(pre1 && g1 != 3'h7)}, 4'h1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    initial begin
        model_reset();
        #12;
        compare();
        rst_n = 1'b1;
        tick();
        // single write, addr 2, data 0101
        req = 1'b1; addr = 2'd2; wdata = 4'b0101;
        tick();
        req = 1'b0;
        repeat (8) tick();
        // preset and req together: preset wins
        preset_all = 1'b1; req = 1'b1; addr = 2'd1; wdata = 4'h9;
        tick();
        preset_all = 1'b0; req = 1'b0;
        repeat (5) tick();
        // write to 3, second request during the sequence is ignored
        req = 1'b1; addr = 2'd3; wdata = 4'ha;
        tick();
        req = 1'b0;
        tick();
        req = 1'b1; addr = 2'd0; wdata = 4'h3;
        tick();
        req = 1'b0;
        repeat (9) tick();
        // req held high: back-to-back writes
        req = 1'b1; addr = 2'd1; wdata = 4'hc;
        repeat (12) tick();
        req = 1'b0;
        repeat (9) tick();
        // asynchronous reset in the middle of a write
        req = 1'b1; addr = 2'd1; wdata = 4'h6;
        tick();
        req = 1'b0;
        tick();
        #3 rst_n = 1'b0;
        #1 model_reset();
        compare();
        tick();
        rst_n = 1'b1; req = 1'b1; addr = 2'd0; wdata = 4'h3;
        tick();
        req = 1'b0;
        repeat (9) tick();
        // random traffic with occasional asynchronous resets
        repeat (500) begin
            req        = $urandom_range(0, 2) == 0;
            preset_all = $urandom_range(0, 9) == 0;
            addr       = 2'($urandom);
            wdata      = 4'($urandom);
            if ($urandom_range(0, 79) == 0) begin
                #2 rst_n = 1'b0;
                #1 model_reset();
                compare();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
